// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key map, special codes,
// debounce state encoding and key classification helpers.
package keypad_pkg;

    // Element i is the code of scanner position i (row i/4, column i%4).
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code >= 4'hA) && (code <= 4'hD);
    endfunction

    function automatic logic [3:0] onehot_index(input logic [15:0] onehot);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (onehot[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the scanner's position/strobe pair and produces a single-cycle
// accept strobe with the mapped key code for each physical press.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] posicion,
    input  logic        opr,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [15:0]   cand_reg, cand_next;
    logic [3:0]    hist_reg;
    logic          armed_reg, armed_next;
    logic          pos_onehot;
    logic          pressed_raw;

    assign pos_onehot  = (posicion != 16'd0) && ((posicion & (posicion - 16'd1)) == 16'd0);
    assign pressed_raw = (|hist_reg) && pos_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            hist_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            hist_reg  <= {hist_reg[2:0], opr};
            armed_reg <= armed_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        armed_next = armed_reg;
        key_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A key still down when reset lifts must be released for a full
                // window before any press is recognised.
                if (!armed_reg) begin
                    if (pressed_raw) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        armed_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (pressed_raw) begin
                    cand_next  = posicion;
                    cnt_next   = '0;
                    state_next = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!pressed_raw) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (posicion != cand_reg) begin
                    cand_next = posicion;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    key_valid  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_HELD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HELD: begin
                if (!pressed_raw) begin
                    cnt_next   = '0;
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (pressed_raw) begin
                    state_next = ST_HELD;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign key_code = KEY_MAP[onehot_index(cand_reg)];

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key events feeding a BCD entry register that
// hands operands plus operator/enter events to the downstream calculator.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DIGITS          = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  posicion,
    input  logic                         opr,
    output logic [3:0]                   key_code,
    output logic                         key_valid,
    output logic [4*DIGITS-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic [4*DIGITS-1:0]          operand,
    output logic [1:0]                   op_code,
    output logic                         op_valid,
    output logic                         enter_valid,
    output logic                         overflow
);

    localparam int EW = 4 * DIGITS;
    localparam int LW = $clog2(DIGITS + 1);

    logic [3:0] acc_code;
    logic       acc_valid;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .posicion  (posicion),
        .opr       (opr),
        .key_code  (acc_code),
        .key_valid (acc_valid)
    );

    // Every effect lands on the same edge that raises key_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            entry       <= '0;
            entry_len   <= '0;
            operand     <= '0;
            op_code     <= '0;
            op_valid    <= 1'b0;
            enter_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            key_valid   <= acc_valid;
            op_valid    <= 1'b0;
            enter_valid <= 1'b0;
            if (acc_valid) begin
                key_code <= acc_code;
                if (is_digit(acc_code)) begin
                    if (entry_len < LW'(DIGITS)) begin
                        entry     <= (entry << 4) | EW'(acc_code);
                        entry_len <= entry_len + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (is_op(acc_code)) begin
                    operand   <= entry;
                    op_code   <= 2'(acc_code - 4'hA);
                    op_valid  <= 1'b1;
                    entry     <= '0;
                    entry_len <= '0;
                end else if (acc_code == KEY_ENTER) begin
                    operand     <= entry;
                    enter_valid <= 1'b1;
                    entry       <= '0;
                    entry_len   <= '0;
                end else if (acc_code == KEY_CLEAR) begin
                    entry     <= '0;
                    entry_len <= '0;
                    overflow  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: each press pushes its expected event,
// the monitor pops and compares when key_valid fires.
module tb_keypad_entry;

    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] posicion;
    logic        opr;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] entry;
    logic [2:0]  entry_len;
    logic [15:0] operand;
    logic [1:0]  op_code;
    logic        op_valid;
    logic        enter_valid;
    logic        overflow;

    keypad_entry #(
        .DEBOUNCE_CYCLES(DC),
        .DIGITS(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .posicion    (posicion),
        .opr         (opr),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .entry       (entry),
        .entry_len   (entry_len),
        .operand     (operand),
        .op_code     (op_code),
        .op_valid    (op_valid),
        .enter_valid (enter_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  len;
        logic [15:0] operand;
        logic [1:0]  opc;
        logic        ovf;
        logic        opv;
        logic        env;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  kmap [16];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          edge_cnt = 0;
    int          last_kv_edge = 0;
    int          press_start_edge = 0;
    logic        kv_prev = 1'b0;

    logic [15:0] m_entry;
    logic [2:0]  m_len;
    logic [15:0] m_operand;
    logic [1:0]  m_opc;
    logic        m_ovf;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_entry   = '0;
        m_len     = '0;
        m_operand = '0;
        m_opc     = '0;
        m_ovf     = 1'b0;
    endtask

    task automatic push_key(input int idx);
        exp_t       e;
        logic [3:0] c;
        c     = kmap[idx];
        e.opv = 1'b0;
        e.env = 1'b0;
        if (c <= 4'd9) begin
            if (m_len < 3'd4) begin
                m_entry = {m_entry[11:0], c};
                m_len   = m_len + 3'd1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (c <= 4'hD) begin
            m_operand = m_entry;
            m_opc     = 2'(c - 4'hA);
            m_entry   = '0;
            m_len     = '0;
            e.opv     = 1'b1;
        end else if (c == 4'hF) begin
            m_operand = m_entry;
            m_entry   = '0;
            m_len     = '0;
            e.env     = 1'b1;
        end else begin
            m_entry = '0;
            m_len   = '0;
            m_ovf   = 1'b0;
        end
        e.code    = c;
        e.entry   = m_entry;
        e.len     = m_len;
        e.operand = m_operand;
        e.opc     = m_opc;
        e.ovf     = m_ovf;
        sb.push_back(e);
    endtask

    // Hold position ia for ca cycles then ib for the rest, opr 1 cycle in 4, then release.
    task automatic press_ex(input int ia, input int ca, input int ib, input int hold, input int exp_idx);
        push_key(exp_idx);
        press_start_edge = edge_cnt;
        for (int i = 0; i < hold; i++) begin
            posicion = 16'(1) << ((i < ca) ? ia : ib);
            opr      = (i % 4 == 0);
            @(negedge clk);
        end
        opr = 1'b0;
        repeat (2 * DC + 6) @(negedge clk);
        check_value("pending_events", 64'(sb.size()), 0);
    endtask

    task automatic press(input int idx);
        press_ex(idx, 40, idx, 40, idx);
    endtask

    task automatic check_all_zero(input string tag);
        check_value(tag, {key_code, key_valid, entry, entry_len, operand, op_code,
                          op_valid, enter_valid, overflow}, 0);
    endtask

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid || op_valid || enter_valid) begin
                check_value("pulse_rules", {op_valid & ~key_valid, enter_valid & ~key_valid,
                                            op_valid & enter_valid, kv_prev & key_valid}, 0);
                if (key_valid) begin
                    last_kv_edge = edge_cnt;
                    if (sb.size() == 0) begin
                        check_value("unexpected_key_valid", 64'(key_valid), 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_value("key_code",    key_code,    e.code);
                        check_value("entry",       entry,       e.entry);
                        check_value("entry_len",   entry_len,   e.len);
                        check_value("operand",     operand,     e.operand);
                        check_value("op_code",     op_code,     e.opc);
                        check_value("overflow",    overflow,    e.ovf);
                        check_value("op_valid",    op_valid,    e.opv);
                        check_value("enter_valid", enter_valid, e.env);
                    end
                end
            end
        end
        kv_prev = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        model_reset();
        rst_n    = 1'b0;
        opr      = 1'b0;
        posicion = 16'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single press of key 2, plus latency from first opr to key_valid.
        press(1);
        check_value("press_latency", 64'(last_kv_edge - press_start_edge), DC + 2);

        // Fill, overflow, clear.
        press(12);
        press(0); press(1); press(2); press(4); press(5);
        press(12);

        // 7 8 A, then 9 #.
        press(8); press(9); press(3);
        press(10); press(14);

        // Contact bounce followed by a stable hold of key 6.
        push_key(6);
        posicion = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            opr = (i % 2 == 0);
            @(negedge clk);
        end
        opr = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            opr = (i % 4 == 0);
            @(negedge clk);
        end
        opr = 1'b0;
        repeat (2 * DC + 6) @(negedge clk);
        check_value("bounce_pending", 64'(sb.size()), 0);

        // Position change while debouncing (takes key 4), then while held (ignored).
        press_ex(0, 3, 4, 40, 4);
        press_ex(9, 20, 10, 40, 9);

        // Reset while key 2 is held with entry 12.
        press(12);
        press(0);
        push_key(1);
        for (int i = 0; i < 20; i++) begin
            posicion = 16'h0002;
            opr      = (i % 4 == 0);
            @(negedge clk);
        end
        check_value("held_pending", 64'(sb.size()), 0);
        check_value("entry_before_reset", entry, 16'h0012);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        sb.delete();
        model_reset();
        for (int i = 20; i < 24; i++) begin
            @(negedge clk);
            opr = (i % 4 == 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            opr = (i % 4 == 0);
            @(negedge clk);
        end
        check_value("held_after_reset_entry", {entry, entry_len}, 0);
        opr = 1'b0;
        repeat (2 * DC + 6) @(negedge clk);

        // Normal operation resumes after the release.
        press(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
